// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: programmable tick generator with free-run (RUN) and
// counted-burst (STEP) modes. It produces a one-cycle tick_en pulse every
// div_eff cycles for a downstream core.
//
// Optional feature macro: CLK_STEP_TICKCNT_EN
//   defined   -> tick_total counts every issued tick (wraps at 2^32).
//   undefined -> tick_total is tied to 0 and no counter flops exist.
//
// Timing: the state register changes on edge E0. A tick is decided in the
// cycle where counter == div_eff-1, and tick_en is registered, so it is seen
// div_eff cycles after E0. If cmd_halt arrives in a tick-deciding cycle, that
// tick is still issued.
module clk_step_ctrl #(
  parameter int unsigned DIV_W       = 28,
  parameter int unsigned DEFAULT_DIV = 500000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic [7:0]       step_count,
  output logic             tick_en,
  output logic             busy,
  output logic [1:0]       state,
  output logic [31:0]      tick_total
);

  localparam int unsigned REM_W = 8;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   divisor_q;
  logic [DIV_W-1:0]   divisor_d;
  logic [DIV_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   cnt_d;
  logic [REM_W-1:0]   remaining_q;
  logic [REM_W-1:0]   remaining_d;
  logic [DIV_W-1:0]   div_last;
  logic               at_end;
  logic               tick_d;
  logic               busy_d;

  // State, divider, burst and registered-output flops
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HALT;
      divisor_q   <= DIV_W'(DEFAULT_DIV);
      cnt_q       <= '0;
      remaining_q <= '0;
      tick_en     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      tick_en     <= tick_d;
      busy        <= busy_d;
    end
  end

  // Next-state, divider, burst bookkeeping and tick decision
  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    busy_d      = 1'b0;

    // A divisor of 0 behaves as 1, so the last count is 0 in both cases
    div_last = (divisor_q == '0) ? '0 : (divisor_q - DIV_W'(1));
    at_end   = (cnt_q == div_last);

    // Ticks depend only on the current state and counter; a same-cycle halt
    // does not suppress a tick that is already due
    tick_d = (state_q != ST_HALT) && at_end;

    unique case (state_q)
      ST_HALT: begin
        if (cmd_halt) begin
          state_d = ST_HALT;
        end else if (cmd_run) begin
          state_d = ST_RUN;
        end else if (cmd_step) begin
          state_d     = ST_STEP;
          remaining_d = (step_count == '0) ? REM_W'(1) : step_count;
        end
        // The divisor is writable only while halted
        if (cfg_we) begin
          divisor_d = cfg_div;
        end
      end
      ST_RUN: begin
        // cmd_step is ignored while free-running
        if (cmd_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (cmd_halt) begin
          state_d = ST_HALT;
        end else if (cmd_run) begin
          state_d = ST_RUN;
        end else if (tick_d) begin
          remaining_d = remaining_q - REM_W'(1);
          if (remaining_q <= REM_W'(1)) begin
            state_d = ST_HALT;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    // The counter restarts on every state change so the first tick in a new
    // mode comes a full period later. It stays at 0 while halted.
    if ((state_d != state_q) || (state_q == ST_HALT)) begin
      cnt_d = '0;
    end else if (at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    busy_d = (state_d != ST_HALT);
  end

  assign state = state_q;

`ifdef CLK_STEP_TICKCNT_EN
  logic [31:0] tick_total_q;

  // Running count of issued ticks; it advances on the same edge as tick_en
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick_total_q <= '0;
    end else if (tick_d) begin
      tick_total_q <= tick_total_q + 32'd1;
    end
  end

  assign tick_total = tick_total_q;
`else
  assign tick_total = '0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl. Stimulus pushes expected tick cycle numbers into a
// queue. A negedge monitor pops one entry per observed tick_en and also
// checks tick_total. Directed checks cover state and busy.
module tb_clk_step_ctrl;

  localparam int unsigned DIV_W = 28;

  logic             clock_in = 1'b0;
  logic             reset    = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [DIV_W-1:0] cfg_div  = '0;
  logic             cmd_run  = 1'b0;
  logic             cmd_halt = 1'b0;
  logic             cmd_step = 1'b0;
  logic [7:0]       step_count = '0;
  logic             tick_en;
  logic             busy;
  logic [1:0]       state;
  logic [31:0]      tick_total;

  int               checks = 0;
  int               errors = 0;
  int unsigned      cyc = 0;
  int unsigned      exp_q[$];
  logic [31:0]      exp_total = '0;
  int unsigned      n;

  clk_step_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(500000)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_div   (cfg_div),
    .cmd_run   (cmd_run),
    .cmd_halt  (cmd_halt),
    .cmd_step  (cmd_step),
    .step_count(step_count),
    .tick_en   (tick_en),
    .busy      (busy),
    .state     (state),
    .tick_total(tick_total)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed tick consumes one expected cycle number
  always @(negedge clock_in) begin
    int unsigned e;
    if (!reset && tick_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick_unexpected: got tick at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e);
      end
`ifdef CLK_STEP_TICKCNT_EN
      exp_total = exp_total + 32'd1;
`endif
      check("tick_total", tick_total, exp_total);
    end
  end

  task automatic push_ticks(input int unsigned start, input int unsigned d, input int unsigned last);
    for (int unsigned t = start + d; t <= last; t += d) exp_q.push_back(t);
  endtask

  task automatic wait_until(input int unsigned m);
    while (cyc < m) @(negedge clock_in);
  endtask

  task automatic cfg(input logic [DIV_W-1:0] d);
    cfg_we = 1'b1; cfg_div = d;
    @(negedge clock_in);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_run(output int unsigned at);
    at = cyc; cmd_run = 1'b1;
    @(negedge clock_in);
    cmd_run = 1'b0;
  endtask

  task automatic pulse_step(input logic [7:0] c, output int unsigned at);
    at = cyc; cmd_step = 1'b1; step_count = c;
    @(negedge clock_in);
    cmd_step = 1'b0;
  endtask

  task automatic halt_at(input int unsigned m);
    wait_until(m);
    cmd_halt = 1'b1;
    @(negedge clock_in);
    cmd_halt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clock_in);
    check("reset_state", 32'(state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tick_en", 32'(tick_en), 32'd0);
    check("reset_tick_total", tick_total, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);

    // DIV=4 free run: ticks 4, 8, 12 cycles after entry, halt off-tick
    cfg(28'd4);
    pulse_run(n);
    push_ticks(n + 1, 4, n + 15);
    check("run_state", 32'(state), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    halt_at(n + 14);
    check("run_halt_state", 32'(state), 32'd0);
    check("run_halt_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clock_in);

    // DIV=3 burst of 5
    cfg(28'd3);
    pulse_step(8'd5, n);
    push_ticks(n + 1, 3, n + 16);
    check("step_state", 32'(state), 32'd2);
    check("step_busy", 32'(busy), 32'd1);
    wait_until(n + 17);
    check("step_done_state", 32'(state), 32'd0);
    check("step_done_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clock_in);

    // step_count=0 gives a single tick
    pulse_step(8'd0, n);
    push_ticks(n + 1, 3, n + 4);
    wait_until(n + 6);
    check("step0_state", 32'(state), 32'd0);
    repeat (5) @(negedge clock_in);

    // Divisor 0 behaves as 1: a tick every cycle
    cfg(28'd0);
    pulse_run(n);
    push_ticks(n + 1, 1, n + 7);
    halt_at(n + 6);
    check("div0_halt_state", 32'(state), 32'd0);
    repeat (5) @(negedge clock_in);

    // All three commands together resolve to HALT
    cmd_halt = 1'b1; cmd_run = 1'b1; cmd_step = 1'b1; step_count = 8'd3;
    @(negedge clock_in);
    cmd_halt = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0;
    check("prio_state", 32'(state), 32'd0);
    check("prio_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clock_in);

    // Config write and cmd_step are dropped in RUN; a halt on a tick cycle keeps that tick
    cfg(28'd2);
    pulse_run(n);
    push_ticks(n + 1, 2, n + 11);
    wait_until(n + 4);
    cfg_we = 1'b1; cfg_div = 28'd7; cmd_step = 1'b1; step_count = 8'd1;
    @(negedge clock_in);
    cfg_we = 1'b0; cmd_step = 1'b0;
    check("run_ignore_step_state", 32'(state), 32'd1);
    halt_at(n + 10);
    check("halt_on_tick_state", 32'(state), 32'd0);
    repeat (5) @(negedge clock_in);

    // Reset mid-burst after 3 of 5 ticks
    cfg(28'd3);
    pulse_step(8'd5, n);
    push_ticks(n + 1, 3, n + 10);
    wait_until(n + 11);
    reset = 1'b1;
    #1;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tick_en", 32'(tick_en), 32'd0);
    check("rst_mid_tick_total", tick_total, 32'd0);
    exp_total = '0;
    repeat (2) @(negedge clock_in);
    reset = 1'b0;
    repeat (20) @(negedge clock_in);
    check("rst_after_state", 32'(state), 32'd0);

`ifdef CLK_STEP_TICKCNT_EN
    // Preset the counter near the top and watch it wrap
    cfg(28'd1);
    dut.tick_total_q = 32'hFFFF_FFFE;
    exp_total = 32'hFFFF_FFFE;
    pulse_run(n);
    push_ticks(n + 1, 1, n + 3);
    halt_at(n + 2);
    repeat (2) @(negedge clock_in);
    check("tick_total_wrap", tick_total, 32'd0);
`else
    check("tick_total_tied", tick_total, 32'd0);
`endif

    repeat (5) @(negedge clock_in);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 28, width of the divisor and divider counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 500000, divisor value loaded at reset.
REQ-003 SHALL have port clock_in  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_we  input  1  divisor write strobe.
REQ-006 SHALL have port cfg_div  input  DIV_W  new divisor value.
REQ-007 SHALL have port cmd_run  input  1  single-cycle pulse requesting free-running ticks.
REQ-008 SHALL have port cmd_halt  input  1  single-cycle pulse requesting stop.
REQ-009 SHALL have port cmd_step  input  1  single-cycle pulse requesting a burst of ticks.
REQ-010 SHALL have port step_count  input  8  burst length, sampled with cmd_step.
REQ-011 SHALL have port tick_en  output  1  one-cycle clock-enable pulse for the downstream core.
REQ-012 SHALL have port busy  output  1  high in RUN or STEP.
REQ-013 SHALL have port state  output  2  current state: 00 HALT, 01 RUN, 10 STEP.
REQ-014 SHALL have port tick_total  output  32  count of issued ticks.

Function
REQ-015 SHALL implement FSM states HALT, RUN and STEP.
REQ-016 SHALL resolve same-cycle commands by priority cmd_halt > cmd_run > cmd_step.
REQ-017 SHALL move to HALT on cmd_halt from any state, clearing the divider counter next cycle.
REQ-018 SHALL move HALT->RUN or STEP->RUN on cmd_run; in RUN, cmd_step SHALL be ignored.
REQ-019 SHALL, on cmd_step in HALT, load remaining = step_count (0 treated as 1) and enter STEP.
REQ-020 SHALL hold divider counter at 0 in HALT; in RUN/STEP it counts 0..div_eff-1 and wraps to 0.
REQ-021 SHALL define div_eff = divisor register, treating value 0 as 1.
REQ-022 SHALL assert tick_en for exactly one cycle when counter == div_eff-1 in RUN or STEP.
REQ-023 SHALL, for div_eff = 1, assert tick_en every cycle in RUN/STEP.
REQ-024 SHALL assert the first tick div_eff cycles after the state register enters RUN or STEP.
REQ-025 SHALL decrement remaining on each STEP tick; the tick with remaining == 1 returns FSM to HALT next cycle.
REQ-026 SHALL accept cfg_we only in HALT (divisor <= cfg_div next cycle); writes in RUN/STEP SHALL be dropped.
REQ-027 SHALL never assert tick_en in HALT, including the cycle cmd_halt is applied if counter had not reached div_eff-1.
REQ-028 SHALL, on a cmd_halt coinciding with a tick cycle, still issue that tick, then halt.
REQ-029 SHALL increment tick_total on every tick_en, wrapping at 2^32-1 to 0.

Reset
REQ-030 SHALL, on reset, set state HALT, counter 0, remaining 0, divisor DEFAULT_DIV, tick_en 0, busy 0, tick_total 0.
REQ-031 SHALL abort any RUN or STEP burst immediately on reset assertion, with no tick issued after it.

Configuration
REQ-032 SHALL implement the tick_total counter only when macro CLK_STEP_TICKCNT_EN is defined.
REQ-033 SHALL, without CLK_STEP_TICKCNT_EN, keep port tick_total and drive it constant 0, with no counter flops.

Verification
REQ-034 SHALL check DIV=4, cmd_run -> tick_en on cycles 4, 8, 12 after RUN entry; busy=1, state=01.
REQ-035 SHALL check DIV=3, cmd_step with step_count=5 -> exactly 5 ticks 3 cycles apart, then state=00, busy=0.
REQ-036 SHALL check cmd_step with step_count=0 -> exactly 1 tick, then HALT; cfg_div=0 -> tick every cycle in RUN.
REQ-037 SHALL check cmd_halt+cmd_run+cmd_step in one cycle -> HALT; cfg_we in RUN with cfg_div=7 -> divisor unchanged.
REQ-038 SHALL check reset asserted mid-STEP (3 of 5 ticks issued) -> state=00, tick_total=0, no further tick_en.
REQ-039 SHALL check tick_total preset near 0xFFFFFFFF wraps to 0 (macro on) and reads 0 throughout (macro off).
